// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core, with a trap state for bad instructions.
// Optional retired-instruction counter enabled by defining RISCV_CTRL_INSTRET_EN.
module riscv_ctrl_fsm #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_run,
  output logic                   o_imem_req,
  input  logic                   i_imem_ack,
  output logic                   o_ir_we,
  input  logic                   i_inst_valid,
  input  logic                   i_is_load,
  input  logic                   i_is_store,
  input  logic                   i_rf_wen_i,
  output logic                   o_dmem_req,
  output logic                   o_dmem_we,
  input  logic                   i_dmem_ack,
  output logic                   o_rf_we,
  output logic                   o_pc_we,
  output logic                   o_halt,
  output logic [2:0]             o_state,
  output logic [WORD_LENGTH-1:0] o_instret
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  state_t r_state;
  logic   r_req_held;
  logic   r_mem_store;
  logic   r_mem_load;

  logic w_imem_req;
  logic w_ir_we;
  logic w_dmem_req;
  logic w_dmem_we;
  logic w_rf_we;
  logic w_pc_we;
  logic w_halt;

  // State register plus the latched fetch-outstanding and memory-direction flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_FETCH;
      r_req_held  <= 1'b0;
      r_mem_store <= 1'b0;
      r_mem_load  <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_imem_req && i_imem_ack) begin
            r_state    <= ST_DECODE;
            r_req_held <= 1'b0;
          end else begin
            r_state    <= ST_FETCH;
            r_req_held <= w_imem_req;
          end
        end
        ST_DECODE: begin
          if (!i_inst_valid) begin
            r_state <= ST_TRAP;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Direction is frozen here so dmem_we stays stable for the whole access; a store beats a load.
          r_mem_store <= i_is_store;
          r_mem_load  <= i_is_load & ~i_is_store;
          if (i_is_load || i_is_store) begin
            r_state <= ST_MEM;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (i_dmem_ack) begin
            if (r_mem_store) begin
              r_state <= ST_FETCH;
            end else begin
              r_state <= ST_WB;
            end
          end else begin
            r_state <= ST_MEM;
          end
        end
        ST_WB: begin
          r_state <= ST_FETCH;
        end
        ST_TRAP: begin
          r_state <= ST_TRAP;
        end
        default: begin
          r_state <= ST_TRAP;
        end
      endcase
    end
  end

  // Moore output decode; only ir_we and the store retirement strobe look at an ack.
  always_comb begin
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_rf_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_halt     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        // Gated by rst_n so the request drops in the same cycle reset asserts.
        w_imem_req = i_rst_n & (i_run | r_req_held);
        w_ir_we    = w_imem_req & i_imem_ack;
      end
      ST_DECODE: begin
        w_halt = 1'b0;
      end
      ST_EXEC: begin
        w_halt = 1'b0;
      end
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = r_mem_store;
        w_pc_we    = r_mem_store & i_dmem_ack;
      end
      ST_WB: begin
        w_rf_we = i_rf_wen_i | r_mem_load;
        w_pc_we = 1'b1;
      end
      ST_TRAP: begin
        w_halt = 1'b1;
      end
      default: begin
        w_halt = 1'b0;
      end
    endcase
  end

  assign o_imem_req = w_imem_req;
  assign o_ir_we    = w_ir_we;
  assign o_dmem_req = w_dmem_req;
  assign o_dmem_we  = w_dmem_we;
  assign o_rf_we    = w_rf_we;
  assign o_pc_we    = w_pc_we;
  assign o_halt     = w_halt;
  assign o_state    = r_state;

`ifdef RISCV_CTRL_INSTRET_EN
  logic [WORD_LENGTH-1:0] r_instret;

  // Retirement counter; wraps naturally and holds in TRAP because pc_we is never raised there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instret <= {WORD_LENGTH{1'b0}};
    end else if (w_pc_we) begin
      r_instret <= r_instret + {{(WORD_LENGTH-1){1'b0}}, 1'b1};
    end else begin
      r_instret <= r_instret;
    end
  end

  assign o_instret = r_instret;
`else
  assign o_instret = {WORD_LENGTH{1'b0}};
`endif

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Scoreboard bench for riscv_ctrl_fsm: the driver queues hand-computed per-cycle expectations, a monitor checks them.
module tb_riscv_ctrl_fsm;

  localparam int WL = 32;
`ifdef RISCV_CTRL_INSTRET_EN
  localparam bit INSTRET_ON = 1'b1;
`else
  localparam bit INSTRET_ON = 1'b0;
`endif

  // Stimulus bits: {rst_n, run, imem_ack, inst_valid, is_load, is_store, rf_wen_i, dmem_ack}
  localparam logic [7:0] R    = 8'b1000_0000;
  localparam logic [7:0] RUN  = 8'b0100_0000;
  localparam logic [7:0] IACK = 8'b0010_0000;
  localparam logic [7:0] VAL  = 8'b0001_0000;
  localparam logic [7:0] LD   = 8'b0000_1000;
  localparam logic [7:0] ST   = 8'b0000_0100;
  localparam logic [7:0] RFW  = 8'b0000_0010;
  localparam logic [7:0] DACK = 8'b0000_0001;

  // Expected outputs: {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt}
  localparam logic [6:0] NONE = 7'b000_0000;
  localparam logic [6:0] IREQ = 7'b100_0000;
  localparam logic [6:0] IRWE = 7'b010_0000;
  localparam logic [6:0] DREQ = 7'b001_0000;
  localparam logic [6:0] DWE  = 7'b000_1000;
  localparam logic [6:0] RFWE = 7'b000_0100;
  localparam logic [6:0] PCWE = 7'b000_0010;
  localparam logic [6:0] HALT = 7'b000_0001;

  typedef struct packed {
    logic [2:0]    st;
    logic [6:0]    outs;
    logic [WL-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          run, imem_ack, inst_valid, is_load, is_store, rf_wen_i, dmem_ack;
  logic          imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt;
  logic [2:0]    state;
  logic [WL-1:0] instret;

  exp_t          exp_q[$];
  string         name_q[$];
  int            n_tests;
  int            n_fail;
  logic [WL-1:0] model_cnt;

  riscv_ctrl_fsm #(.WORD_LENGTH(WL)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_run        (run),
    .o_imem_req   (imem_req),
    .i_imem_ack   (imem_ack),
    .o_ir_we      (ir_we),
    .i_inst_valid (inst_valid),
    .i_is_load    (is_load),
    .i_is_store   (is_store),
    .i_rf_wen_i   (rf_wen_i),
    .o_dmem_req   (dmem_req),
    .o_dmem_we    (dmem_we),
    .i_dmem_ack   (dmem_ack),
    .o_rf_we      (rf_we),
    .o_pc_we      (pc_we),
    .o_halt       (halt),
    .o_state      (state),
    .o_instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus, applied 1 time unit after the rising edge, plus its expectation.
  task automatic cyc(input string nm, input logic [7:0] in, input logic [2:0] est, input logic [6:0] eo);
    exp_t e;
    @(posedge clk);
    #1;
    {rst_n, run, imem_ack, inst_valid, is_load, is_store, rf_wen_i, dmem_ack} = in;
    if (!in[7]) model_cnt = '0;
    e.st   = est;
    e.outs = eo;
    e.cnt  = INSTRET_ON ? model_cnt : '0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (eo[1] && in[7]) model_cnt = model_cnt + 32'd1;
  endtask

  // Monitor: compares the DUT against the oldest queued expectation, mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    logic [6:0] got;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halt};
      n_tests = n_tests + 1;
      if (state !== e.st || got !== e.outs || instret !== e.cnt) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got state=%0d outs=%b instret=%0d, want state=%0d outs=%b instret=%0d",
                 nm, state, got, instret, e.st, e.outs, e.cnt);
      end
    end
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    model_cnt = '0;
    {rst_n, run, imem_ack, inst_valid, is_load, is_store, rf_wen_i, dmem_ack} = 8'h00;

    // Reset held with run and a stray ack: nothing may be requested.
    cyc("rst_hold", RUN | IACK, 3'd0, NONE);

    // ADD, zero-wait fetch; acks during DECODE are ignored.
    cyc("add_f",  R | RUN | IACK, 3'd0, IREQ | IRWE);
    cyc("add_d",  R | RUN | VAL | IACK | DACK, 3'd1, NONE);
    cyc("add_e",  R | RUN | RFW, 3'd2, NONE);
    cyc("add_wb", R | RUN | RFW, 3'd4, RFWE | PCWE);

    // LW with data ack delayed 3 cycles; rf_wen_i low in WB, load still writes.
    cyc("lw_f",  R | RUN | IACK, 3'd0, IREQ | IRWE);
    cyc("lw_d",  R | VAL, 3'd1, NONE);
    cyc("lw_e",  R | LD | RFW, 3'd2, NONE);
    for (int i = 0; i < 3; i++) cyc("lw_mwait", R | LD, 3'd3, DREQ);
    cyc("lw_mack", R | LD | DACK, 3'd3, DREQ);
    cyc("lw_wb",   R, 3'd4, RFWE | PCWE);

    // SW zero-wait: retires from MEM, no register write.
    cyc("sw_f", R | RUN | IACK, 3'd0, IREQ | IRWE);
    cyc("sw_d", R | VAL, 3'd1, NONE);
    cyc("sw_e", R | ST, 3'd2, NONE);
    cyc("sw_m", R | ST | RFW | DACK, 3'd3, DREQ | DWE | PCWE);

    // Load and store both flagged: the store wins.
    cyc("ls_f",    R | RUN | IACK, 3'd0, IREQ | IRWE);
    cyc("ls_d",    R | VAL, 3'd1, NONE);
    cyc("ls_e",    R | LD | ST, 3'd2, NONE);
    cyc("ls_mwait", R | LD | ST | RUN, 3'd3, DREQ | DWE);
    cyc("ls_mack", R | LD | ST | DACK, 3'd3, DREQ | DWE | PCWE);

    // Idle with run low: a stray imem_ack is ignored.
    for (int i = 0; i < 2; i++) cyc("idle_ack", R | IACK, 3'd0, NONE);

    // Run drops after the request rises; request held until ack, then idles.
    cyc("dr_f0", R | RUN, 3'd0, IREQ);
    cyc("dr_f1", R, 3'd0, IREQ);
    cyc("dr_f2", R | IACK, 3'd0, IREQ | IRWE);
    cyc("dr_d",  R | VAL, 3'd1, NONE);
    cyc("dr_e",  R, 3'd2, NONE);
    cyc("dr_wb", R | RFW, 3'd4, RFWE | PCWE);
    for (int i = 0; i < 2; i++) cyc("dr_idle", R, 3'd0, NONE);

    // Invalid instruction traps; acks and run have no effect; reset recovers.
    cyc("tr_f",   R | RUN | IACK, 3'd0, IREQ | IRWE);
    cyc("tr_d",   R | RUN, 3'd1, NONE);
    cyc("tr_h0",  R | RUN | IACK | DACK, 3'd5, HALT);
    cyc("tr_h1",  R | IACK | VAL, 3'd5, HALT);
    cyc("tr_h2",  R | RUN | DACK, 3'd5, HALT);
    cyc("tr_rst", RUN | IACK, 3'd0, NONE);
    cyc("tr_rel", R, 3'd0, NONE);

    // One ADD so the counter is nonzero, then reset in the middle of a load's MEM wait.
    cyc("m_af",  R | RUN | IACK, 3'd0, IREQ | IRWE);
    cyc("m_ad",  R | VAL, 3'd1, NONE);
    cyc("m_ae",  R | RFW, 3'd2, NONE);
    cyc("m_awb", R | RFW, 3'd4, RFWE | PCWE);
    cyc("m_lf",  R | RUN | IACK, 3'd0, IREQ | IRWE);
    cyc("m_ld",  R | VAL, 3'd1, NONE);
    cyc("m_le",  R | LD, 3'd2, NONE);
    cyc("m_mw",  R | LD, 3'd3, DREQ);
    cyc("m_rst", LD, 3'd0, NONE);
    cyc("m_late", R | LD | DACK, 3'd0, NONE);
    cyc("m_idle", R, 3'd0, NONE);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_ctrl_fsm.md
# riscv_ctrl_fsm

Multi-cycle sequencer for the RV32I core. Steps each instruction through fetch, decode, execute, memory and write-back. Drives instruction/data memory request handshakes and the PC, IR and register-file write enables. Consumes the decoder's classification signals and halts in a trap state on an unrecognised instruction.

## Interface
- `WORD_LENGTH`, 32, datapath width; sets the width of `instret`.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `run`  in  1  permission to start a new fetch; sampled only in FETCH before a request is issued.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch data valid this cycle.
- `ir_we`  out  1  IR load strobe; one cycle.
- `inst_valid`  in  1  decoder recognised the instruction in IR.
- `is_load`  in  1  decoder: write-back source is memory.
- `is_store`  in  1  decoder: memory write.
- `rf_wen_i`  in  1  decoder: instruction writes rd.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data request is a write.
- `dmem_ack`  in  1  data access complete this cycle.
- `rf_we`  out  1  register-file write enable; one cycle.
- `pc_we`  out  1  PC update strobe; one cycle; marks retirement.
- `halt`  out  1  trap taken; core stopped.
- `state`  out  3  current state encoding, for debug.
- `instret`  out  WORD_LENGTH  retired-instruction count.

## Operation
- State encoding:
  - FETCH=0
  - DECODE=1
  - EXEC=2
  - MEM=3
  - WB=4
  - TRAP=5
  - Codes 6 and 7 are illegal and go to TRAP.
- FETCH
  - `imem_req`=`run`, or held at 1 once asserted, until `imem_ack`.
  - On `imem_ack`&&`imem_req`: `ir_we`=1 in that cycle, next state DECODE.
- DECODE
  - One cycle, lets the decoder settle.
  - `!inst_valid` → TRAP; otherwise → EXEC.
- EXEC
  - One cycle, ALU evaluates.
  - `is_load`||`is_store` → MEM; otherwise → WB.
- MEM
  - `dmem_req`=1 and `dmem_we`=`is_store`, held stable until `dmem_ack`.
  - If `is_load` and `is_store` are both set, the store wins: `dmem_we`=1.
  - On ack, a store asserts `pc_we`=1 and goes to FETCH. A load goes to WB.
- WB
  - `rf_we`=`rf_wen_i`, or 1 for a load.
  - `pc_we`=1.
  - Next state FETCH.
- TRAP
  - `halt`=1. All strobes and requests are 0.
  - Stays in TRAP until `rst_n` is asserted.
- Outputs are Moore, decoded from state plus the listed inputs. No output depends on `imem_ack`/`dmem_ack` except `ir_we` and the store-path `pc_we`.

## Timing
- Reset (asynchronous, immediate):
  - state=FETCH.
  - `imem_req`, `ir_we`, `dmem_req`, `dmem_we`, `rf_we`, `pc_we`, `halt` = 0.
  - `instret`=0.
- Latency with a zero-wait ack (ack high in the first request cycle):
  - ALU, branch, JAL, LUI, AUIPC: 4 cycles FETCH→FETCH.
  - Load: 5 cycles.
  - Store: 4 cycles (retires from MEM).
- Each wait cycle on either ack adds 1 cycle. There is no timeout.
- Handshake:
  - A request, once asserted, is never withdrawn before its ack, even if `run` falls.
  - An ack with no request asserted is ignored.
  - An ack in any state other than FETCH or MEM is ignored.
- `run` low in FETCH with no request outstanding: the block idles in FETCH with all outputs 0.
- Reset mid-transaction: requests drop in the same cycle as reset. An ack arriving after reset is ignored. Memories must tolerate an abandoned request.
- Each retired instruction raises exactly one `pc_we` pulse. `rf_we` and `pc_we` coincide in WB.

## Configuration
- `RISCV_CTRL_INSTRET_EN`
  - Defined: `instret` increments by 1 on every cycle with `pc_we`=1 and wraps modulo 2^WORD_LENGTH. It is cleared only by reset and holds its value in TRAP.
  - Undefined: `instret` is tied to 0 and no counter flops are inferred.

## Test plan
- Reset, `run`=1, ADD encoding, zero-wait `imem_ack` → states 0,1,2,4,0. `ir_we` in cycle 0, `rf_we`=`pc_we`=1 in cycle 3, `instret`=1.
- LW with `dmem_ack` delayed 3 cycles → `dmem_req`=1 and `dmem_we`=0 held for 4 cycles. WB follows with `rf_we`=1. Total 8 cycles.
- SW, zero-wait → `dmem_we`=1 in MEM, `pc_we`=1 in MEM, `rf_we` never asserted, next state FETCH after 4 cycles.
- `inst_valid`=0 in DECODE → TRAP by cycle 2 with `halt`=1. Subsequent acks and `run` toggles have no effect. `rst_n` pulse returns to FETCH with `halt`=0.
- Drop `run` after `imem_req` rises with ack delayed 2 cycles → request held until ack, instruction completes, then idles in FETCH with `imem_req`=0.
- Assert `rst_n`=0 during MEM wait → `dmem_req`=0 immediately and state=0. A late `dmem_ack` is ignored. With the macro defined, `instret` is reset to 0.
